// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    // IDLE arbitrates; RMW_WR spends one cycle writing back a merged sub-word store.
    typedef enum logic [0:0] {
        IDLE,
        RMW_WR
    } arb_state_e;

    localparam logic [31:0] TOHOST_ADDR = 32'h8000_1000;
    localparam logic [31:0] MEM_BASE    = 32'h8000_0000;
    localparam logic [3:0]  BE_FULL     = 4'b1111;

endpackage

// File: rtl/byte_merge.sv
// Byte-lane merge of a new word into an old word under a byte-enable mask.
// Purely combinational; also intended for the cache fill path.
module byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  be,
    output logic [31:0] merged
);

    // Each byte lane comes from new_word when its enable is set, else from old_word.
    always_comb begin
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port word memory between instruction fetch and load/store.
// Sub-word stores become a read-modify-write: read and merge in the grant cycle,
// write back in the following RMW_WR cycle.
// Optional tohost monitor enabled by defining TOHOST_MON_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] m_addr,
    input  logic [31:0]       m_rdata,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_waddr,
    output logic [31:0]       m_wdata,
    output logic              halt,
    output logic              pass
);

    localparam logic [7:0] Limit = 8'(STARVE_LIMIT);

    arb_state_e        state_q, state_d;
    logic [7:0]        starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0] rmw_addr_q;
    logic [31:0]       rmw_data_q;
    logic [31:0]       merged_word;
    logic [ADDR_W-1:0] if_word_addr, d_word_addr;
    logic              store_partial;
    logic              d_resp;
    logic              d_load;

    // Low address bits are deliberately ignored; misalignment is not checked.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

    assign if_word_addr  = {if_addr[ADDR_W-1:2], 2'b00};
    assign d_word_addr   = {d_addr[ADDR_W-1:2], 2'b00};
    assign store_partial = d_we && (d_be != 4'b0000) && (d_be != BE_FULL);

    byte_merge u_byte_merge (
        .old_word (m_rdata),
        .new_word (d_wdata),
        .be       (d_be),
        .merged   (merged_word)
    );

    // Grant, memory drive and next state; grants and writes are suppressed during reset.
    always_comb begin
        state_d = state_q;
        if_gnt  = 1'b0;
        d_gnt   = 1'b0;
        m_addr  = if_word_addr;
        m_we    = 1'b0;
        m_waddr = d_word_addr;
        m_wdata = '0;
        d_resp  = 1'b0;
        d_load  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rst) begin
                    // Data normally wins; a fetch starved for STARVE_LIMIT cycles is forced in.
                    if (if_req && (!d_req || starve_cnt_q == Limit)) begin
                        if_gnt = 1'b1;
                    end else if (d_req) begin
                        d_gnt = 1'b1;
                    end
                end
                if (d_gnt) begin
                    m_addr = d_word_addr;
                    d_load = !d_we;
                    d_resp = !store_partial;
                    if (d_we && d_be == BE_FULL) begin
                        m_we    = 1'b1;
                        m_wdata = d_wdata;
                    end else if (store_partial) begin
                        state_d = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                state_d = IDLE;
                m_waddr = rmw_addr_q;
                if (!rst) begin
                    m_we    = 1'b1;
                    m_wdata = rmw_data_q;
                    d_resp  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Starvation counter: saturating count of cycles fetch requests without a grant.
    always_comb begin
        starve_cnt_d = '0;
        if (if_req && !if_gnt) begin
            starve_cnt_d = (starve_cnt_q == Limit) ? Limit : starve_cnt_q + 8'd1;
        end
    end

    // State, counter, RMW capture and one-cycle-latency response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            rmw_addr_q   <= '0;
            rmw_data_q   <= '0;
            if_rvalid    <= 1'b0;
            if_rdata     <= '0;
            d_rvalid     <= 1'b0;
            d_rdata      <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            if_rvalid    <= if_gnt;
            d_rvalid     <= d_resp;
            if (if_gnt) begin
                if_rdata <= m_rdata;
            end
            if (d_resp) begin
                d_rdata <= d_load ? m_rdata : 32'h0;
            end
            if (state_d == RMW_WR) begin
                rmw_addr_q <= d_word_addr;
                rmw_data_q <= merged_word;
            end
        end
    end

`ifdef TOHOST_MON_EN
    localparam logic [ADDR_W-1:0] TohostAddr = ADDR_W'(TOHOST_ADDR);

    logic halt_q, pass_q;

    // Latch the first odd-valued tohost write; later ones are ignored until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_q <= 1'b0;
            pass_q <= 1'b0;
        end else if (!halt_q && m_we && m_waddr == TohostAddr && m_wdata[0]) begin
            halt_q <= 1'b1;
            pass_q <= (m_wdata == 32'h1);
        end
    end

    assign halt = halt_q;
    assign pass = pass_q;
`else
    assign halt = 1'b0;
    assign pass = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of arbitration, latency and memory contents.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned LIMIT = 4;
    localparam int unsigned AW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req, d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt, d_rvalid;
    logic [31:0]   d_rdata;
    logic [AW-1:0] m_addr, m_waddr;
    logic [31:0]   m_rdata, m_wdata;
    logic          m_we, halt, pass;

    int n_cmp = 0;
    int n_fail = 0;

    // 1 KiB word memory at MEM_BASE; writes outside the window are dropped.
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    always #5 clk = ~clk;

    assign m_rdata = mem[m_addr[9:2]];

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (m_we && m_waddr >= MEM_BASE && m_waddr < MEM_BASE + 32'd1024)
            mem[m_waddr[9:2]] <= m_wdata;
    end

    mem_port_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .ADDR_W       (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .m_addr    (m_addr),
        .m_rdata   (m_rdata),
        .m_we      (m_we),
        .m_waddr   (m_waddr),
        .m_wdata   (m_wdata),
        .halt      (halt),
        .pass      (pass)
    );

    task automatic preload(input int idx, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = 8'(idx); pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        if_req = 1'b1; if_addr = MEM_BASE;
        d_req = 1'b1; d_we = 1'b1; d_be = BE_FULL; d_addr = MEM_BASE; d_wdata = 32'h1234_5678;
        #1;
        n_cmp++;
        if (if_gnt !== 1'b0 || d_gnt !== 1'b0 || m_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_gnt if_gnt=%b d_gnt=%b m_we=%b required 0/0/0", if_gnt, d_gnt, m_we);
        end
        n_cmp++;
        if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_resp if_rvalid=%b d_rvalid=%b if_rdata=%h d_rdata=%h required all 0",
                     if_rvalid, d_rvalid, if_rdata, d_rdata);
        end
        n_cmp++;
        if (halt !== 1'b0 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_halt halt=%b pass=%b required 0/0", halt, pass);
        end
        if_req = 1'b0; d_req = 1'b0;
        // Fill memory while still in reset.
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            pl_en = 1'b1; pl_idx = 8'(i); pl_data = $urandom;
        end
        @(negedge clk);
        pl_en = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_fetch_only();
        preload(0, 32'h0000_0297);
        @(negedge clk);
        if_req = 1'b1; if_addr = MEM_BASE; #1;
        n_cmp++;
        if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || m_addr !== MEM_BASE) begin
            n_fail++;
            $display("FAIL fetch_gnt if_gnt=%b d_gnt=%b m_addr=%h required 1/0/%h",
                     if_gnt, d_gnt, m_addr, MEM_BASE);
        end
        @(negedge clk);
        if_req = 1'b0; #1;
        n_cmp++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h0000_0297) begin
            n_fail++;
            $display("FAIL fetch_data if_rvalid=%b if_rdata=%h required 1/00000297", if_rvalid, if_rdata);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (if_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_pulse if_rvalid=%b required 0", if_rvalid);
        end
    endtask

    task automatic test_collision();
        bit exp_if;
        preload(64, 32'h0BAD_F00D);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = MEM_BASE;
            d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = MEM_BASE + 32'h100;
            #1;
            exp_if = (i == 4);
            n_cmp++;
            if (if_gnt !== exp_if || d_gnt !== !exp_if) begin
                n_fail++;
                $display("FAIL collision_gnt cycle=%0d if_gnt=%b d_gnt=%b required %b/%b",
                         i, if_gnt, d_gnt, exp_if, !exp_if);
            end
            if (i >= 1 && i <= 4) begin
                n_cmp++;
                if (d_rvalid !== 1'b1 || d_rdata !== 32'h0BAD_F00D) begin
                    n_fail++;
                    $display("FAIL collision_load cycle=%0d d_rvalid=%b d_rdata=%h required 1/0badf00d",
                             i, d_rvalid, d_rdata);
                end
            end
            if (i == 5) begin
                n_cmp++;
                if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || if_rdata !== 32'h0000_0297) begin
                    n_fail++;
                    $display("FAIL collision_fetch if_rvalid=%b d_rvalid=%b if_rdata=%h required 1/0/00000297",
                             if_rvalid, d_rvalid, if_rdata);
                end
            end
        end
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0; #1;
        n_cmp++;
        if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_tail d_rvalid=%b if_rvalid=%b required 1/0", d_rvalid, if_rvalid);
        end
    endtask

    task automatic test_partial_store();
        preload(4, 32'h1122_3344);
        @(negedge clk);
        if_req = 1'b1; if_addr = MEM_BASE + 32'h8;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0010; d_addr = MEM_BASE + 32'h11; d_wdata = 32'h0000_AA00;
        #1;
        n_cmp++;
        if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || m_we !== 1'b0 || m_addr !== MEM_BASE + 32'h10) begin
            n_fail++;
            $display("FAIL rmw_grant d_gnt=%b if_gnt=%b m_we=%b m_addr=%h required 1/0/0/%h",
                     d_gnt, if_gnt, m_we, m_addr, MEM_BASE + 32'h10);
        end
        @(negedge clk);
        d_req = 1'b0; #1;
        n_cmp++;
        if (m_we !== 1'b1 || m_wdata !== 32'h1122_AA44 || m_waddr !== MEM_BASE + 32'h10) begin
            n_fail++;
            $display("FAIL rmw_write m_we=%b m_wdata=%h m_waddr=%h required 1/1122aa44/%h",
                     m_we, m_wdata, m_waddr, MEM_BASE + 32'h10);
        end
        n_cmp++;
        if (if_gnt !== 1'b0 || d_gnt !== 1'b0 || d_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rmw_block if_gnt=%b d_gnt=%b d_rvalid=%b required 0/0/0", if_gnt, d_gnt, d_rvalid);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || if_gnt !== 1'b1 || m_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rmw_ack d_rvalid=%b d_rdata=%h if_gnt=%b m_we=%b required 1/0/1/0",
                     d_rvalid, d_rdata, if_gnt, m_we);
        end
        if_req = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (mem[4] !== 32'h1122_AA44) begin
            n_fail++;
            $display("FAIL rmw_mem word=%h required 1122aa44", mem[4]);
        end
    endtask

    task automatic test_full_store_load();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_be = BE_FULL; d_addr = MEM_BASE + 32'h20; d_wdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if (d_gnt !== 1'b1 || m_we !== 1'b1 || m_waddr !== MEM_BASE + 32'h20 || m_wdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL full_store d_gnt=%b m_we=%b m_waddr=%h m_wdata=%h required 1/1/%h/deadbeef",
                     d_gnt, m_we, m_waddr, m_wdata, MEM_BASE + 32'h20);
        end
        @(negedge clk);
        d_we = 1'b0; d_be = 4'h0; d_wdata = 32'h0; #1;
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || d_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL store_ack d_rvalid=%b d_rdata=%h d_gnt=%b required 1/0/1", d_rvalid, d_rdata, d_gnt);
        end
        @(negedge clk);
        d_req = 1'b0; #1;
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL load_back d_rvalid=%b d_rdata=%h required 1/deadbeef", d_rvalid, d_rdata);
        end
    endtask

    task automatic test_reset_mid_rmw();
        preload(12, 32'h5566_7788);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0001; d_addr = MEM_BASE + 32'h30; d_wdata = 32'h0000_00FF;
        @(negedge clk);
        d_req = 1'b0; rst = 1'b1; #1;
        n_cmp++;
        if (m_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_rmw_we m_we=%b required 0", m_we);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (d_rvalid !== 1'b0 || mem[12] !== 32'h5566_7788) begin
            n_fail++;
            $display("FAIL rst_rmw_abandon d_rvalid=%b word=%h required 0/55667788", d_rvalid, mem[12]);
        end
    endtask

    task automatic test_random();
        int unsigned starve = 0;
        bit          busy = 0;
        bit          i_pend = 0, d_pend = 0;
        bit          exp_iv = 0;
        logic [31:0] exp_id = '0;
        int          due_q[$];
        logic [31:0] dat_q[$];
        bit          gi, gd, ev;
        logic [31:0] ed, mask;
        logic [AW-1:0] off;
        int          ii, di;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        for (int cyc = 0; cyc < 808; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if (if_rvalid !== exp_iv || (exp_iv && if_rdata !== exp_id)) begin
                n_fail++;
                $display("FAIL rand_fetch_resp cycle=%0d if_rvalid=%b if_rdata=%h required %b/%h",
                         cyc, if_rvalid, if_rdata, exp_iv, exp_id);
            end
            ev = (due_q.size() > 0) && (due_q[0] == cyc);
            ed = ev ? dat_q[0] : 32'h0;
            n_cmp++;
            if (d_rvalid !== ev || (ev && d_rdata !== ed)) begin
                n_fail++;
                $display("FAIL rand_data_resp cycle=%0d d_rvalid=%b d_rdata=%h required %b/%h",
                         cyc, d_rvalid, d_rdata, ev, ed);
            end
            if (ev) begin
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end
            n_cmp++;
            if (halt !== 1'b0 || pass !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_halt cycle=%0d halt=%b pass=%b required 0/0", cyc, halt, pass);
            end
            if (cyc < 800 && !i_pend && $urandom_range(0, 3) != 0) begin
                i_pend  = 1'b1;
                if_addr = MEM_BASE + 32'($urandom_range(0, 255));
            end
            if (cyc < 800 && !d_pend && $urandom_range(0, 3) != 0) begin
                d_pend  = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = MEM_BASE + 32'($urandom_range(0, 255));
                d_wdata = $urandom;
                case ($urandom_range(0, 3))
                    0:       d_be = 4'h0;
                    1:       d_be = BE_FULL;
                    default: d_be = 4'($urandom_range(1, 14));
                endcase
            end
            if_req = i_pend; d_req = d_pend;
            #1;
            gi = !busy && i_pend && (!d_pend || starve == LIMIT);
            gd = !busy && d_pend && !gi;
            n_cmp++;
            if (if_gnt !== gi || d_gnt !== gd) begin
                n_fail++;
                $display("FAIL rand_gnt cycle=%0d if_gnt=%b d_gnt=%b required %b/%b starve=%0d",
                         cyc, if_gnt, d_gnt, gi, gd, starve);
            end
            off = if_addr - MEM_BASE; ii = int'(off >> 2);
            off = d_addr - MEM_BASE;  di = int'(off >> 2);
            if (gi || gd) begin
                n_cmp++;
                if (m_addr !== ((gi ? if_addr : d_addr) & ~32'h3)) begin
                    n_fail++;
                    $display("FAIL rand_maddr cycle=%0d m_addr=%h required %h",
                             cyc, m_addr, (gi ? if_addr : d_addr) & ~32'h3);
                end
            end
            busy   = 1'b0;
            starve = (i_pend && !gi) ? ((starve == LIMIT) ? LIMIT : starve + 1) : 0;
            exp_iv = gi;
            if (gi) begin
                exp_id = ref_mem[ii];
                i_pend = 1'b0;
            end
            if (gd) begin
                d_pend = 1'b0;
                if (!d_we) begin
                    due_q.push_back(cyc + 1);
                    dat_q.push_back(ref_mem[di]);
                end else begin
                    mask = {{8{d_be[3]}}, {8{d_be[2]}}, {8{d_be[1]}}, {8{d_be[0]}}};
                    ref_mem[di] = (ref_mem[di] & ~mask) | (d_wdata & mask);
                    busy = (d_be != 4'h0) && (d_be != BE_FULL);
                    due_q.push_back(busy ? cyc + 2 : cyc + 1);
                    dat_q.push_back(32'h0);
                end
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            n_cmp++;
            if (mem[i] !== ref_mem[i]) begin
                n_fail++;
                $display("FAIL rand_mem word=%0d got=%h required %h", i, mem[i], ref_mem[i]);
            end
        end
    endtask

`ifdef TOHOST_MON_EN
    task automatic test_tohost();
        logic [31:0] first, later;
        for (int t = 0; t < 2; t++) begin
            first = (t == 0) ? 32'h0000_0001 : 32'h0000_0007;
            later = (t == 0) ? 32'h0000_0007 : 32'h0000_0001;
            @(negedge clk); rst = 1'b1;
            @(negedge clk); rst = 1'b0;
            @(negedge clk);
            d_req = 1'b1; d_we = 1'b1; d_be = BE_FULL; d_addr = TOHOST_ADDR; d_wdata = first;
            #1;
            n_cmp++;
            if (halt !== 1'b0) begin
                n_fail++;
                $display("FAIL tohost_pre run=%0d halt=%b required 0", t, halt);
            end
            @(negedge clk);
            d_req = 1'b0; #1;
            n_cmp++;
            if (halt !== 1'b1 || pass !== (t == 0)) begin
                n_fail++;
                $display("FAIL tohost_set run=%0d halt=%b pass=%b required 1/%b", t, halt, pass, t == 0);
            end
            @(negedge clk);
            d_req = 1'b1; d_wdata = later;
            @(negedge clk);
            d_req = 1'b0; #1;
            n_cmp++;
            if (halt !== 1'b1 || pass !== (t == 0)) begin
                n_fail++;
                $display("FAIL tohost_sticky run=%0d halt=%b pass=%b required 1/%b", t, halt, pass, t == 0);
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        test_reset();
        test_fetch_only();
        test_collision();
        test_partial_store();
        test_full_store_load();
        test_reset_mid_rmw();
        test_random();
`ifdef TOHOST_MON_EN
        test_tohost();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
